// File: rtl/dn_input_pkg.sv
// Shared types and default constants for the input debouncer.
//
// Contents:
//   db_state_t             per-channel debounce FSM state
//   CLK_FREQ_HZ            board clock frequency
//   DEBOUNCE_MS            debounce window in milliseconds
//   STABLE_CYCLES_DEFAULT  debounce window in clock cycles (10 ms at 100 MHz)
//   SYNC_STAGES_DEFAULT    default synchronizer depth
package dn_input_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } db_state_t;

    localparam int unsigned CLK_FREQ_HZ           = 100_000_000;
    localparam int unsigned DEBOUNCE_MS           = 10;
    localparam int unsigned STABLE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned SYNC_STAGES_DEFAULT   = 2;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: metastability synchronizer, debounce FSM with a
// run-length counter, registered clean level and one-cycle edge pulses.
//
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   raw_i    asynchronous raw switch/button level
//   level_o  debounced level (registered)
//   rise_o   one-cycle pulse in the first cycle level_o reads 1
//   fall_o   one-cycle pulse in the first cycle level_o reads 0
module debounce_channel
    import dn_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEFAULT,   // legal range 2..4
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT  // must be >= 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    // Count value at which the next agreeing sample completes the window.
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;

    db_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // Synchronizer shift chain; bit 0 samples the raw pin.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign sync   = sync_q[SYNC_STAGES-1];

    // State register: synchronizer, FSM, counter and outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic. The state leaves the wait state on the terminal count,
    // so the counter never exceeds STABLE_CYCLES-1 and cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOW: begin
                if (sync) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_RISE_WAIT;
                        cnt_d   = CntOne;
                    end
                end
            end
            S_RISE_WAIT: begin
                if (!sync) begin
                    // Glitch: run too short, drop it silently.
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_FALL_WAIT;
                        cnt_d   = CntOne;
                    end
                end
            end
            S_FALL_WAIT: begin
                if (sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. Decoding from state_d lets the level and its pulse land on
    // the same edge as the state change, with no extra cycle of latency.
    always_comb begin
        level_d = (state_d == S_HIGH) || (state_d == S_FALL_WAIT);
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch/button conditioner. Each channel is synchronized and
// debounced independently; outputs are the concatenation of all channels.
//
// Ports:
//   clk       system clock (100 MHz on board)
//   rst       synchronous active-low reset
//   raw_in    [WIDTH] asynchronous raw levels
//   db_level  [WIDTH] debounced levels
//   db_rise   [WIDTH] one-cycle pulses on debounced 0->1
//   db_fall   [WIDTH] one-cycle pulses on debounced 1->0
module input_debouncer
    import dn_input_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEFAULT,   // legal range 2..4
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT  // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_level,
    output logic [WIDTH-1:0] db_rise,
    output logic [WIDTH-1:0] db_fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk_i   (clk),
            .rst_ni  (rst),
            .raw_i   (raw_in[i]),
            .level_o (db_level[i]),
            .rise_o  (db_rise[i]),
            .fall_o  (db_fall[i])
        );
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions raw board switches/buttons before they reach the counter stages (e.g. the up/down select of the 4-bit Gray-code counter).
- Per channel: metastability synchronizer, debounce state machine, clean level output, and single-cycle rise/fall pulses.
- Sits directly upstream of the counter. db_level drives its up_down input; rise/fall pulses are available for step/load controls.

Parameters:
- WIDTH, 2, number of independent input channels.
- SYNC_STAGES, 2, synchronizer flip-flop depth (legal range 2..4).
- STABLE_CYCLES, 1000000, consecutive mismatching samples needed to accept a new level (10 ms at 100 MHz). Must be >= 1.

Ports:
- clk  input  1  system clock (100 MHz on board).
- rst  input  1  synchronous, active-low reset. Sampled only on the rising edge of clk; low = reset.
- raw_in  input  WIDTH  asynchronous raw switch/button levels.
- db_level  output  WIDTH  debounced level per channel.
- db_rise  output  WIDTH  one-cycle pulse when db_level goes 0->1.
- db_fall  output  WIDTH  one-cycle pulse when db_level goes 1->0.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All synchronizer flops, counters and outputs go to 0.
  - Every channel FSM goes to S_LOW.
  - Reset mid-count aborts the count; no pulse is generated by reset itself.
- Synchronizer: raw_in[i] passes through SYNC_STAGES flops. sync[i] is the last stage.
- Per-channel FSM states: S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT.
  - S_LOW: sync==1 -> cnt<=1, go S_RISE_WAIT. If STABLE_CYCLES==1, go directly S_HIGH instead.
  - S_RISE_WAIT: sync==0 -> cnt<=0, back to S_LOW (glitch rejected, no pulse). sync==1 and cnt+1==STABLE_CYCLES -> S_HIGH. Otherwise cnt<=cnt+1.
  - S_HIGH and S_FALL_WAIT: mirror image of S_LOW/S_RISE_WAIT.
- Outputs:
  - db_level[i] is registered and equals 1 exactly in S_HIGH and S_FALL_WAIT.
  - db_rise[i] is registered and high for exactly the one cycle in which db_level first reads 1. db_fall is symmetric.
  - db_rise and db_fall are never high together on one channel.
- Latency: raw change first sampled at edge k -> db_level/pulse update at edge k+SYNC_STAGES+STABLE_CYCLES-1.
- Any mismatch run shorter than STABLE_CYCLES samples produces no output change.
- Counter width is $clog2(STABLE_CYCLES+1). The counter saturates by construction and never wraps, because the state changes at the terminal count.
- Channels are fully independent. Simultaneous transitions on several channels each pulse in their own cycle with no interaction.
- Raw high while in reset: after reset release the input is treated as a new 0->1 change. db_rise fires after the full latency.
- Input toggling every cycle indefinitely: db_level holds its current value forever.

Decomposition:
- Package dn_input_pkg:
  - typedef enum logic [1:0] db_state_t {S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT}.
  - Default-constant localparams for STABLE_CYCLES at 100 MHz.
- Sub-module debounce_channel: one synchronizer + FSM + counter for a single bit.
- input_debouncer instantiates WIDTH copies via generate and concatenates the outputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, WIDTH=2 unless noted):
- Reset: hold rst=0 for 3 cycles with raw_in=2'b11 -> db_level=0, db_rise=0, db_fall=0 throughout reset.
- Clean rise: raw_in[0] 0->1 sampled at edge k, held -> db_level[0]=1 and db_rise[0]=1 at edge k+5. db_rise[0]=0 at k+6. Channel 1 is unaffected.
- Glitch rejection: raw_in[0]=1 for 3 cycles, then 0 -> db_level[0] stays 0, no pulses. A 4-cycle high run produces db_rise[0] exactly once.
- Clean fall: from db_level[0]=1, raw_in[0]->0 held -> db_fall[0] for one cycle at edge k+5, db_level[0]=0 thereafter.
- Reset mid-count: raw_in[1] goes high and rst=0 is asserted 2 cycles later for 1 cycle -> no pulse. After release with raw still high, db_rise[1] fires 5 edges after the first post-reset sampling edge.
- STABLE_CYCLES=1 build: raw_in[0] 0->1 sampled at edge k -> db_level[0]=1 and db_rise[0]=1 at edge k+2.
